// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-register definitions: control-bundle bit positions,
// per-stage bundle widths and the EX/MEM packed bundle layouts.
`timescale 1ns/1ps
package pipe_stage_reg_pkg;

  localparam int unsigned CTRL_W_DEF    = 24;
  localparam int unsigned DATA_W_DEF    = 240;
  localparam int unsigned ID_EX_CTRL_W  = 24;
  localparam int unsigned ID_EX_DATA_W  = 240;
  localparam int unsigned EX_MEM_CTRL_W = 24;
  localparam int unsigned EX_MEM_DATA_W = 240;
  localparam int unsigned MEM_WB_CTRL_W = 24;
  localparam int unsigned MEM_WB_DATA_W = 240;

  // Control-bundle bit positions (LSB first)
  localparam int unsigned REGWR      = 0;
  localparam int unsigned MEMWR      = 1;
  localparam int unsigned MEMTOREG   = 2;
  localparam int unsigned BEQ        = 3;
  localparam int unsigned BNE        = 4;
  localparam int unsigned JUMP       = 5;
  localparam int unsigned JAL        = 6;
  localparam int unsigned JALR       = 7;
  localparam int unsigned MULT       = 8;
  localparam int unsigned MTLO       = 9;
  localparam int unsigned MTHI       = 10;
  localparam int unsigned ALUOP_LSB  = 11;
  localparam int unsigned ALUOP_MSB  = 18;
  localparam int unsigned RW_LSB     = 19;
  localparam int unsigned RW_MSB     = 23;

  typedef struct packed {
    logic [4:0] rw;
    logic [7:0] alu_op;
    logic       mthi;
    logic       mtlo;
    logic       mult;
    logic       jalr;
    logic       jal;
    logic       jump;
    logic       bne;
    logic       beq;
    logic       memtoreg;
    logic       memwr;
    logic       regwr;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] busa;
    logic [31:0] busb;
    logic [31:0] target;
    logic [15:0] imm16;
    logic [63:0] mult_res;
  } ex_mem_data_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages.
`timescale 1ns/1ps
interface pipe_stage_reg_if #(
  parameter int unsigned CTRL_W = 24,
  parameter int unsigned DATA_W = 240
) ();

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry: valid + ctrl + data. Clear wins over load and only
// zeroes valid/ctrl, leaving the data bundle as it was.
`timescale 1ns/1ps
module pipe_slot #(
  parameter int unsigned CTRL_W = 24,
  parameter int unsigned DATA_W = 240
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;

  // Entry state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      ctrl_r  <= '0;
      data_r  <= '0;
    end else if (clr) begin
      valid_r <= 1'b0;
      ctrl_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      ctrl_r  <= ld_ctrl;
      data_r  <= ld_data;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign ctrl  = ctrl_r;
  assign data  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional
// two-entry skid buffer and synchronous flush.
`timescale 1ns/1ps
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SKID   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  pipe_stage_reg_if.slave        up,
  pipe_stage_reg_if.master       dn,
  output logic [1:0]             occupancy
);

  logic              main_valid_s, skid_valid_s;
  logic [CTRL_W-1:0] main_ctrl_s, skid_ctrl_s, main_ld_ctrl_s;
  logic [DATA_W-1:0] main_data_s, skid_data_s, main_ld_data_s;
  logic              ready_s, accept_s, xfer_s;
  logic              main_load_s, main_clr_s, main_src_skid_s;
  logic              skid_load_s, skid_clr_s;
  logic              main_valid_nxt_s, skid_valid_nxt_s;
  logic [1:0]        occ_r;

  // With a skid slot, ready depends only on a register bit
  assign ready_s  = (SKID != 0) ? (!skid_valid_s && !flush)
                                : ((dn.ready || !main_valid_s) && !flush);
  assign accept_s = up.valid && ready_s;
  assign xfer_s   = main_valid_s && dn.ready;

  // Slot load/clear decisions
  always_comb begin
    main_load_s     = 1'b0;
    main_clr_s      = 1'b0;
    main_src_skid_s = 1'b0;
    skid_load_s     = 1'b0;
    skid_clr_s      = 1'b0;
    if (flush) begin
      main_clr_s = 1'b1;
      skid_clr_s = 1'b1;
    end else if (SKID != 0) begin
      if (skid_valid_s) begin
        if (xfer_s) begin
          main_load_s     = 1'b1;
          main_src_skid_s = 1'b1;
          skid_clr_s      = 1'b1;
        end else begin
          main_load_s = 1'b0;
        end
      end else if (accept_s && (!main_valid_s || xfer_s)) begin
        main_load_s = 1'b1;
      end else if (accept_s) begin
        skid_load_s = 1'b1;
      end else if (xfer_s) begin
        main_clr_s = 1'b1;
      end else begin
        main_load_s = 1'b0;
      end
    end else begin
      if (accept_s) begin
        main_load_s = 1'b1;
      end else if (xfer_s) begin
        main_clr_s = 1'b1;
      end else begin
        main_load_s = 1'b0;
      end
    end
  end

  assign main_ld_ctrl_s = main_src_skid_s ? skid_ctrl_s : up.ctrl;
  assign main_ld_data_s = main_src_skid_s ? skid_data_s : up.data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load_s),
    .clr     (main_clr_s),
    .ld_ctrl (main_ld_ctrl_s),
    .ld_data (main_ld_data_s),
    .valid   (main_valid_s),
    .ctrl    (main_ctrl_s),
    .data    (main_data_s)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load_s),
        .clr     (skid_clr_s),
        .ld_ctrl (up.ctrl),
        .ld_data (up.data),
        .valid   (skid_valid_s),
        .ctrl    (skid_ctrl_s),
        .data    (skid_data_s)
      );
    end else begin : g_no_skid
      assign skid_valid_s = 1'b0;
      assign skid_ctrl_s  = '0;
      assign skid_data_s  = '0;
    end
  endgenerate

  assign main_valid_nxt_s = main_clr_s ? 1'b0 : (main_load_s ? 1'b1 : main_valid_s);
  assign skid_valid_nxt_s = skid_clr_s ? 1'b0 : (skid_load_s ? 1'b1 : skid_valid_s);

  // Occupancy kept as its own register so the output has no adder behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= 2'd0;
    end else begin
      occ_r <= {1'b0, main_valid_nxt_s} + {1'b0, skid_valid_nxt_s};
    end
  end

  assign up.ready  = ready_s;
  assign dn.valid  = main_valid_s;
  assign dn.ctrl   = main_ctrl_s & {CTRL_W{main_valid_s}};
  assign dn.data   = main_data_s;
  assign occupancy = occ_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: SKID=1 and SKID=0 instances checked every cycle
// against a bounded-FIFO reference model.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [23:0]  c;
    logic [239:0] d;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic         iv   [2];
  logic [23:0]  ic   [2];
  logic [239:0] idat [2];
  logic         ordy [2];
  logic         fl   [2];

  logic         ov   [2];
  logic         ir   [2];
  logic [23:0]  oc   [2];
  logic [239:0] od   [2];
  logic [1:0]   occ  [2];

  ent_t         mq    [2][$];
  logic [239:0] shown [2];

  pipe_stage_reg_if #(.CTRL_W(24), .DATA_W(240)) up0 ();
  pipe_stage_reg_if #(.CTRL_W(24), .DATA_W(240)) dn0 ();
  pipe_stage_reg_if #(.CTRL_W(24), .DATA_W(240)) up1 ();
  pipe_stage_reg_if #(.CTRL_W(24), .DATA_W(240)) dn1 ();
  logic [1:0] occ0, occ1;

  pipe_stage_reg #(.CTRL_W(24), .DATA_W(240), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]), .up(up0), .dn(dn0), .occupancy(occ0));
  pipe_stage_reg #(.CTRL_W(24), .DATA_W(240), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]), .up(up1), .dn(dn1), .occupancy(occ1));

  assign up0.valid = iv[0];
  assign up0.ctrl  = ic[0];
  assign up0.data  = idat[0];
  assign dn0.ready = ordy[0];
  assign up1.valid = iv[1];
  assign up1.ctrl  = ic[1];
  assign up1.data  = idat[1];
  assign dn1.ready = ordy[1];

  assign ov[0]  = dn0.valid;
  assign ov[1]  = dn1.valid;
  assign ir[0]  = up0.ready;
  assign ir[1]  = up1.ready;
  assign oc[0]  = dn0.ctrl;
  assign oc[1]  = dn1.ctrl;
  assign od[0]  = dn0.data;
  assign od[1]  = dn1.data;
  assign occ[0] = occ0;
  assign occ[1] = occ1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [239:0] rnd240();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[239:0];
  endfunction

  // dut0 holds one entry, dut1 holds two
  function automatic logic exp_ready(int k);
    int n = mq[k].size();
    if (k == 0) return (ordy[k] || n == 0) && !fl[k];
    return (n < 2) && !fl[k];
  endfunction

  task automatic chk(input string tag, input int k, input logic [239:0] obs, input logic [239:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_dut(input int k);
    int n = mq[k].size();
    chk("out_valid", k, 240'(ov[k]), 240'(n > 0));
    chk("out_ctrl",  k, 240'(oc[k]), (n > 0) ? 240'(mq[k][0].c) : 240'(0));
    chk("out_data",  k, od[k], (n > 0) ? mq[k][0].d : shown[k]);
    chk("occupancy", k, 240'(occ[k]), 240'(n));
    chk("in_ready",  k, 240'(ir[k]), 240'(exp_ready(k)));
  endtask

  // Check at negedge, then advance both models across the rising edge
  task automatic cycle();
    logic acc [2];
    logic xf  [2];
    ent_t e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk_dut(k);
      acc[k] = iv[k] && exp_ready(k);
      xf[k]  = (mq[k].size() > 0) && ordy[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || fl[k]) begin
        mq[k].delete();
      end else begin
        if (xf[k]) void'(mq[k].pop_front());
        if (acc[k]) begin
          e.c = ic[k];
          e.d = idat[k];
          mq[k].push_back(e);
        end
      end
      if (mq[k].size() > 0) shown[k] = mq[k][0].d;
    end
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic [23:0] c);
    iv[k]   = v;
    ic[k]   = c;
    idat[k] = rnd240();
  endtask

  logic [239:0] a_data;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ic[k] = 24'h0; idat[k] = 240'h0;
      ordy[k] = 1'b1; fl[k] = 1'b0; shown[k] = 240'h0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 240'(ov[k]), 240'(0));
      chk("rst_ctrl",  k, 240'(oc[k]), 240'(0));
      chk("rst_data",  k, od[k], 240'(0));
      chk("rst_occ",   k, 240'(occ[k]), 240'(0));
    end
    rst_n = 1'b1;
    cycle();

    // Back-to-back stream on both instances
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 2; k++) drive(k, 1'b1, 24'($urandom));
      cycle();
    end
    for (int k = 0; k < 2; k++) iv[k] = 1'b0;
    cycle();

    // Stall with two entries held in dut1
    ordy[1] = 1'b0;
    drive(1, 1'b1, 24'hA0A0A0);
    cycle();
    drive(1, 1'b1, 24'hB0B0B0);
    cycle();
    iv[1] = 1'b0;
    repeat (3) cycle();
    chk("stall_occ",   1, 240'(occ[1]), 240'(2));
    chk("stall_ready", 1, 240'(ir[1]), 240'(0));
    ordy[1] = 1'b1;
    repeat (3) cycle();

    // Flush while full, with an all-ones instruction offered
    ordy[1] = 1'b0;
    drive(1, 1'b1, 24'h111111);
    a_data = idat[1];
    cycle();
    drive(1, 1'b1, 24'h222222);
    cycle();
    fl[1] = 1'b1;
    drive(1, 1'b1, 24'hFFFFFF);
    cycle();
    fl[1] = 1'b0;
    iv[1] = 1'b0;
    chk("flush_valid", 1, 240'(ov[1]), 240'(0));
    chk("flush_ctrl",  1, 240'(oc[1]), 240'(0));
    chk("flush_data",  1, od[1], a_data);
    cycle();

    // Upstream bubble between two all-ones instructions
    ordy[1] = 1'b1;
    drive(1, 1'b1, 24'hFFFFFF);
    a_data = idat[1];
    cycle();
    iv[1] = 1'b0;
    cycle();
    drive(1, 1'b1, 24'hFFFFFF);
    chk("gap_valid", 1, 240'(ov[1]), 240'(0));
    chk("gap_ctrl",  1, 240'(oc[1]), 240'(0));
    chk("gap_data",  1, od[1], a_data);
    cycle();
    iv[1] = 1'b0;
    cycle();

    // Asynchronous reset in the middle of a full stall
    ordy[1] = 1'b0;
    drive(1, 1'b1, 24'h0F0F0F);
    cycle();
    drive(1, 1'b1, 24'hF0F0F0);
    cycle();
    iv[1] = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 1, 240'(ov[1]), 240'(0));
    chk("arst_ctrl",  1, 240'(oc[1]), 240'(0));
    chk("arst_data",  1, od[1], 240'(0));
    chk("arst_occ",   1, 240'(occ[1]), 240'(0));
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      shown[k] = 240'h0;
    end
    cycle();
    rst_n = 1'b1;
    cycle();

    // Random traffic on both instances
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 2; k++) begin
        drive(k, 1'($urandom_range(0, 1)), 24'($urandom));
        ordy[k] = 1'($urandom_range(0, 1));
      end
      fl[1] = ($urandom_range(0, 31) == 0);
      cycle();
    end
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; fl[k] = 1'b0;
    end
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
